// File: rtl/ofdm_pkg.sv
// Shared state type, default sizes and frame-length helpers for the OFDM zero-pad stream.
package ofdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    POST = 2'd3
  } zp_state_t;

  localparam int OFDM_N_DATA   = 64;
  localparam int OFDM_PAD      = 32;
  localparam int OFDM_SAMPLE_W = 16;

  // Samples per IFFT frame; the DC null adds one zero between the data halves.
  function automatic int zp_frame_len(input int n_data, input int pad_lo,
                                      input int pad_hi, input bit dc_null);
    return pad_lo + n_data + pad_hi + (dc_null ? 1 : 0);
  endfunction

  // Index counter width for a counter running 0..count-1 (at least one bit).
  function automatic int zp_idx_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/ofdm_out_reg.sv
// Single-entry valid/ready output register carrying an I/Q sample plus frame markers.
module ofdm_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_i,
  input  logic [DATA_W-1:0] load_q,
  input  logic              load_first,
  input  logic              load_last,
  output logic              slot_free,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_first,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  always_comb begin
    slot_free = !valid_q || out_ready;
    valid_d   = valid_q;
    i_d       = i_q;
    q_d       = q_q;
    first_d   = first_q;
    last_d    = last_q;
    // A stalled beat keeps every field frozen until the consumer takes it.
    if (slot_free) begin
      valid_d = load_valid;
      i_d     = load_i;
      q_d     = load_q;
      first_d = load_first;
      last_d  = load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_i     = i_q;
  assign out_q     = q_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule

// File: rtl/ofdm_zero_pad_stream.sv
// Back-pressured zero-padding inserter: PAD_LO zeros, N_DATA samples, PAD_HI zeros per frame.
// Define ZP_DC_NULL_EN to insert one zero (DC null) between the two data halves.
module ofdm_zero_pad_stream
  import ofdm_pkg::*;
#(
  parameter int DATA_W = OFDM_SAMPLE_W,
  parameter int N_DATA = OFDM_N_DATA,
  parameter int PAD_LO = OFDM_PAD,
  parameter int PAD_HI = OFDM_PAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int PAD_MAX = (PAD_LO > PAD_HI) ? PAD_LO : PAD_HI;
  localparam int DIDX_W  = zp_idx_width(N_DATA);
  localparam int PIDX_W  = zp_idx_width(PAD_MAX);

  localparam logic [DIDX_W-1:0] DATA_LAST = DIDX_W'(N_DATA - 1);
  localparam logic [PIDX_W-1:0] PRE_LAST  = PIDX_W'(PAD_LO - 1);
  localparam logic [PIDX_W-1:0] POST_LAST = PIDX_W'(PAD_HI - 1);
  localparam zp_state_t AFTER_IDLE = (PAD_LO == 0) ? DATA : PRE;
  localparam zp_state_t AFTER_DATA = (PAD_HI == 0) ? IDLE : POST;

  zp_state_t         state_q, state_d;
  logic [DIDX_W-1:0] data_idx_q, data_idx_d;
  logic [PIDX_W-1:0] pad_idx_q, pad_idx_d;
`ifdef ZP_DC_NULL_EN
  localparam logic [DIDX_W-1:0] HALF_LAST = DIDX_W'(N_DATA / 2 - 1);
  logic              dc_q, dc_d;
`endif

  logic              slot_free;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_i;
  logic [DATA_W-1:0] ld_q;
  logic              ld_first;
  logic              ld_last;

  always_comb begin
    state_d    = state_q;
    data_idx_d = data_idx_q;
    pad_idx_d  = pad_idx_q;
`ifdef ZP_DC_NULL_EN
    dc_d       = dc_q;
`endif
    in_ready   = 1'b0;
    ld_valid   = 1'b0;
    ld_i       = '0;
    ld_q       = '0;
    ld_first   = 1'b0;
    ld_last    = 1'b0;

    case (state_q)
      // The waiting sample is only observed here; it is consumed in DATA.
      IDLE: begin
        if (in_valid) begin
          state_d = AFTER_IDLE;
        end
      end

      PRE: begin
        if (slot_free) begin
          ld_valid = 1'b1;
          ld_first = (pad_idx_q == '0);
          if (pad_idx_q == PRE_LAST) begin
            pad_idx_d = '0;
            state_d   = DATA;
          end else begin
            pad_idx_d = pad_idx_q + 1'b1;
          end
        end
      end

      DATA: begin
`ifdef ZP_DC_NULL_EN
        if (dc_q) begin
          if (slot_free) begin
            ld_valid = 1'b1;
            dc_d     = 1'b0;
          end
        end else begin
`else
        begin
`endif
          in_ready = slot_free;
          // No input with a free slot leaves a bubble; zeros never stand in for data.
          if (in_valid && slot_free) begin
            ld_valid = 1'b1;
            ld_i     = in_i;
            ld_q     = in_q;
            ld_first = (PAD_LO == 0) && (data_idx_q == '0);
            if (data_idx_q == DATA_LAST) begin
              ld_last    = (PAD_HI == 0);
              data_idx_d = '0;
              state_d    = AFTER_DATA;
            end else begin
              data_idx_d = data_idx_q + 1'b1;
`ifdef ZP_DC_NULL_EN
              if (data_idx_q == HALF_LAST) begin
                dc_d = 1'b1;
              end
`endif
            end
          end
        end
      end

      POST: begin
        if (slot_free) begin
          ld_valid = 1'b1;
          if (pad_idx_q == POST_LAST) begin
            ld_last   = 1'b1;
            pad_idx_d = '0;
            state_d   = IDLE;
          end else begin
            pad_idx_d = pad_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_idx_q <= '0;
      pad_idx_q  <= '0;
`ifdef ZP_DC_NULL_EN
      dc_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_idx_q <= data_idx_d;
      pad_idx_q  <= pad_idx_d;
`ifdef ZP_DC_NULL_EN
      dc_q       <= dc_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);

  ofdm_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_valid(ld_valid),
    .load_i    (ld_i),
    .load_q    (ld_q),
    .load_first(ld_first),
    .load_last (ld_last),
    .slot_free (slot_free),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_first (out_first),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_ofdm_zero_pad_stream.sv
// Self-checking bench: frame model built from the padding rules, checked every cycle against two DUT configurations.
module tb_ofdm_zero_pad_stream;

`ifdef ZP_DC_NULL_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif
  localparam int FL_A  = 128 + DC_EN;
  localparam int FL_B  = 8 + DC_EN;
  localparam int LIMIT = 20000;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        first;
    logic        last;
    logic        dc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_i = '0;
  logic [15:0] in_q = '0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_first, a_out_last, a_busy;
  logic [15:0] a_out_i, a_out_q;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy;
  logic [15:0] b_out_i, b_out_q;

  logic        m_valid, m_in_ready, m_first, m_last, m_busy;
  logic [15:0] m_i, m_q;

  int checks = 0;
  int errors = 0;
  int cur_n = 64, cur_lo = 32, cur_hi = 32;
  int out_cnt = 0;
  int cyc_n = 0;
  int last_first_cyc = -1;
  int first_gap = 0;

  beat_t       exp_q[$];
  beat_t       e;
  logic        prev_stall = 1'b0, prev_xfer = 1'b0, prev_in_ready = 1'b0;
  logic [33:0] prev_out;
  logic [31:0] prev_in;

  always #5 clk = ~clk;

  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;
  assign m_valid    = sel ? b_out_valid : a_out_valid;
  assign m_in_ready = sel ? b_in_ready  : a_in_ready;
  assign m_first    = sel ? b_out_first : a_out_first;
  assign m_last     = sel ? b_out_last  : a_out_last;
  assign m_busy     = sel ? b_busy      : a_busy;
  assign m_i        = sel ? b_out_i     : a_out_i;
  assign m_q        = sel ? b_out_q     : a_out_q;

  ofdm_zero_pad_stream u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_i(a_out_i), .out_q(a_out_q),
    .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy)
  );

  ofdm_zero_pad_stream #(.DATA_W(16), .N_DATA(8), .PAD_LO(0), .PAD_HI(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_i(b_out_i), .out_q(b_out_q),
    .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Frame = lo zeros ++ data (optional zero at the middle) ++ hi zeros; markers on both ends.
  task automatic push_frame();
    beat_t fr[$];
    beat_t b;
    for (int z = 0; z < cur_lo; z++) fr.push_back('0);
    for (int k = 1; k <= cur_n; k++) begin
      if (DC_EN != 0 && k == cur_n / 2 + 1) begin
        b = '0;
        b.dc = 1'b1;
        fr.push_back(b);
      end
      b = '0;
      b.i = 16'(k);
      b.q = 16'(-k);
      fr.push_back(b);
    end
    for (int z = 0; z < cur_hi; z++) fr.push_back('0);
    b = fr[0];
    b.first = 1'b1;
    fr[0] = b;
    b = fr[fr.size() - 1];
    b.last = 1'b1;
    fr[fr.size() - 1] = b;
    foreach (fr[n]) exp_q.push_back(fr[n]);
  endtask

  task automatic run(input int nf, input int rand_ready, input int gaps, input int abort_at);
    int k = 0;
    int gap = 0;
    int cyc = 0;
    int total = nf * cur_n;
    out_cnt = 0;
    for (int f = 0; f < nf; f++) push_frame();
    while ((k < total || exp_q.size() != 0) && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (abort_at >= 0 && out_cnt >= abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 64'(m_valid), 64'd0);
        chk("abort_busy", 64'(m_busy), 64'd0);
        exp_q.delete();
        return;
      end
      out_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k < total && gap == 0) begin
        in_valid = 1'b1;
        in_i = 16'((k % cur_n) + 1);
        in_q = 16'(-((k % cur_n) + 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (gap > 0) begin
        gap--;
      end else if (in_valid && m_in_ready) begin
        k++;
        if (gaps != 0 && (k % 8) == 0) gap = 3;
      end
    end
    chk("run_within_budget", 64'(cyc < LIMIT), 64'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      prev_stall    = 1'b0;
      prev_xfer     = 1'b0;
      prev_in_ready = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {29'd0, m_valid, m_i, m_q, m_first, m_last}, {29'd0, 1'b1, prev_out});
      if (prev_xfer)
        chk("latency1", {31'd0, m_valid, m_i, m_q}, {31'd0, 1'b1, prev_in});
      if (m_valid && !prev_stall && exp_q.size() != 0 && exp_q[0].dc)
        chk("dc_null_in_ready_low", 64'(prev_in_ready), 64'd0);
      if (m_valid && out_ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", out_cnt), {30'd0, m_i, m_q, m_first, m_last},
              {30'd0, e.i, e.q, e.first, e.last});
        end
        if (m_first) begin
          if (last_first_cyc >= 0) first_gap = cyc_n - last_first_cyc;
          last_first_cyc = cyc_n;
        end
        out_cnt++;
      end
      prev_stall    = m_valid && !out_ready;
      prev_out      = {m_i, m_q, m_first, m_last};
      prev_xfer     = in_valid && m_in_ready;
      prev_in       = {in_i, in_q};
      prev_in_ready = m_in_ready;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {58'd0, a_in_ready, a_out_valid, a_out_first, a_out_last, a_busy, |{a_out_i, a_out_q}}, 64'd0);
    chk("reset_b", {58'd0, b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy, |{b_out_i, b_out_q}}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Model pins for the default geometry.
    push_frame();
    chk("pin_len_a", 64'(exp_q.size()), 64'(FL_A));
    chk("pin_first_a", {63'd0, exp_q[0].first}, 64'd1);
    chk("pin_pad_lo_end", 64'(exp_q[31].i), 64'd0);
    chk("pin_data_start", {32'd0, exp_q[32].i, exp_q[32].q}, {32'd0, 16'd1, 16'hFFFF});
    chk("pin_data_end", 64'(exp_q[95 + DC_EN].i), 64'd64);
    chk("pin_last_a", {62'd0, exp_q[FL_A - 2].last, exp_q[FL_A - 1].last}, 64'd1);
`ifdef ZP_DC_NULL_EN
    chk("pin_dc_null", {47'd0, exp_q[64].dc, exp_q[64].i}, {47'd0, 1'b1, 16'd0});
    chk("pin_second_half", 64'(exp_q[65].i), 64'd33);
`endif
    exp_q.delete();

    run(1, 0, 0, -1);
    chk("count_plain", 64'(out_cnt), 64'(FL_A));
    run(1, 1, 0, -1);
    chk("count_random_ready", 64'(out_cnt), 64'(FL_A));
    run(1, 0, 1, -1);
    chk("count_gaps", 64'(out_cnt), 64'(FL_A));
    last_first_cyc = -1;
    first_gap = 0;
    run(2, 0, 0, -1);
    chk("frame_period", 64'(first_gap), 64'(FL_A + 1));
    run(1, 0, 0, 70);
    run(1, 0, 0, -1);
    chk("count_after_abort", 64'(out_cnt), 64'(FL_A));

    repeat (2) @(posedge clk);
    #1;
    sel = 1'b1;
    cur_n = 8;
    cur_lo = 0;
    cur_hi = 0;
    push_frame();
    chk("pin_len_b", 64'(exp_q.size()), 64'(FL_B));
    chk("pin_first_b", {47'd0, exp_q[0].first, exp_q[0].i}, {47'd0, 1'b1, 16'd1});
    chk("pin_last_b", {47'd0, exp_q[FL_B - 1].last, exp_q[FL_B - 1].i}, {47'd0, 1'b1, 16'd8});
    exp_q.delete();
    run(1, 0, 0, -1);
    chk("count_b", 64'(out_cnt), 64'(FL_B));
    run(2, 1, 0, -1);
    chk("count_b_b2b", 64'(out_cnt), 64'(2 * FL_B));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
